// File: rtl/uart_tx_buf_if.sv
// uart_tx_buf_if
// Byte-stream handshake carrying bytes into the UART transmit buffer.
// Signal names are given from the buffer's (slave's) point of view.
//   i_s_axis_tvalid : producer has a byte on i_s_axis_tdata
//   o_s_axis_tready : buffer can accept a byte this cycle
//   i_s_axis_tdata  : byte to transmit
// Modports: master (byte producer), slave (uart_tx_buf).
interface uart_tx_buf_if;
    logic       i_s_axis_tvalid;
    logic       o_s_axis_tready;
    logic [7:0] i_s_axis_tdata;

    modport master (
        output i_s_axis_tvalid,
        output i_s_axis_tdata,
        input  o_s_axis_tready
    );

    modport slave (
        input  i_s_axis_tvalid,
        input  i_s_axis_tdata,
        output o_s_axis_tready
    );
endinterface

// File: rtl/uart_tx_buf.sv
// uart_tx_buf
// Buffered UART transmitter: a FIFO of bytes feeding an 8-bit LSB-first
// serializer (start bit, 8 data bits, optional even parity, one stop bit).
// Optional feature macro: UART_TX_BUF_PARITY_EN adds an even-parity bit.
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit (4..65535)
//   FIFO_DEPTH   : byte buffer depth, power of two (2..256)
// Ports:
//   i_clk        : clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   s_axis       : byte input handshake (uart_tx_buf_if.slave)
//   o_txd        : serial output, idle high
//   o_txd_busy   : high while the serializer is in any non-IDLE state
//   o_txd_done   : one-cycle pulse on the last cycle of each stop bit
//   o_fifo_count : bytes waiting in the buffer (excludes the byte on the line)
//
// Serializer states:
//   state    | meaning
//   S_IDLE   | line idle, waiting for a buffered byte
//   S_START  | start bit (low)
//   S_DATA   | data bits, LSB first
//   S_PARITY | even-parity bit (parity builds only)
//   S_STOP   | stop bit (high); pops the next byte on its last cycle
module uart_tx_buf #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    uart_tx_buf_if.slave                  s_axis,
    output logic                          o_txd,
    output logic                          o_txd_busy,
    output logic                          o_txd_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_BUF_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [AW:0]    r_count;
    logic           r_rdy;
    logic [CW-1:0]  r_clk_cnt;
    logic [2:0]     r_bit_idx;
    logic [7:0]     r_shift;
    logic           r_txd;
    logic           w_tready, w_push, w_pop, w_have, w_tick, w_done, w_txd_nxt;
`ifdef UART_TX_BUF_PARITY_EN
    logic           r_parity;
`endif

    // r_rdy keeps tready low during reset and for no longer than the first
    // edge after release.
    assign w_tready = r_rdy && (r_count != FULL_CNT);
    assign w_push   = s_axis.i_s_axis_tvalid && w_tready;
    assign w_have   = (r_count != '0);
    assign w_tick   = (r_clk_cnt == BIT_LAST);

    assign s_axis.o_s_axis_tready = w_tready;
    assign o_fifo_count           = r_count;
    assign o_txd                  = r_txd;
    assign o_txd_busy             = (r_state != S_IDLE);
    assign o_txd_done             = w_done;

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= s_axis.i_s_axis_tdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdy    <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rdy <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        w_txd_nxt   = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_have) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_txd_nxt = 1'b0;
                if (w_tick) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                w_txd_nxt = r_shift[r_bit_idx];
                if (w_tick && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_BUF_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_TX_BUF_PARITY_EN
            S_PARITY: begin
                w_txd_nxt = r_parity;
                if (w_tick) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    w_done = 1'b1;
                    if (w_have) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The line is registered from the current state, so it trails the state
    // by one cycle; reset still forces it high asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
`ifdef UART_TX_BUF_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_txd <= w_txd_nxt;
            if (w_pop) begin
                r_shift  <= r_mem[r_rd_ptr];
`ifdef UART_TX_BUF_PARITY_EN
                r_parity <= ^r_mem[r_rd_ptr];
`endif
            end
            if (w_state_nxt != r_state) begin
                r_clk_cnt <= '0;
                r_bit_idx <= '0;
            end else if (r_state != S_IDLE) begin
                if (w_tick) begin
                    r_clk_cnt <= '0;
                    if (r_state == S_DATA) r_bit_idx <= r_bit_idx + 3'd1;
                end else begin
                    r_clk_cnt <= r_clk_cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_buf.sv
module tb_uart_tx_buf;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_TX_BUF_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       txd, busy, done;
    logic [2:0] fcnt;

    always #5 clk = ~clk;

    uart_tx_buf_if s_axis ();

    uart_tx_buf #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .s_axis       (s_axis),
        .o_txd        (txd),
        .o_txd_busy   (busy),
        .o_txd_done   (done),
        .o_fifo_count (fcnt)
    );

    typedef struct {
        logic [7:0] d;
        logic       p;
    } exp_t;

    exp_t sb[$];
    int   starts[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   frames = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Serial receiver: samples each bit at its centre, compares to scoreboard.
    bit         rx_act = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_par = 1'b0;
    always @(negedge clk) begin
        int k;
        if (!rst_n) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (txd === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
                starts.push_back(cyc);
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == CPB/2) begin
                check("rx start bit", {31'd0, txd}, 32'd0);
            end else if (rx_cnt % CPB == CPB/2) begin
                k = rx_cnt / CPB;
                if (k <= 8) begin
                    rx_byte[k-1] = txd;
                end else if (k == NBITS - 1) begin
                    check("rx stop bit", {31'd0, txd}, 32'd1);
                    frames++;
                    rx_act = 1'b0;
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL rx unexpected frame: got byte %02h, expected no frame", rx_byte);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("rx data", {24'd0, rx_byte}, {24'd0, e.d});
`ifdef UART_TX_BUF_PARITY_EN
                        check("rx parity", {31'd0, rx_par}, {31'd0, e.p});
`endif
                    end
                end else begin
                    rx_par = txd;
                end
            end
        end
    end

    // Full-buffer watcher: tready must track the buffer fill level.
    bit watch_full = 1'b0;
    int max_cnt = 0;
    always @(negedge clk) begin
        if (watch_full) begin
            if (int'(fcnt) > max_cnt) max_cnt = int'(fcnt);
            if (fcnt == 3'd4) check("tready low when full", {31'd0, s_axis.o_s_axis_tready}, 32'd0);
            else              check("tready high when not full", {31'd0, s_axis.o_s_axis_tready}, 32'd1);
        end
    end

    task automatic push(input logic [7:0] d, input logic p, output int acc);
        bit ok;
        bit rdy;
        ok = 1'b0;
        @(negedge clk);
        s_axis.i_s_axis_tvalid = 1'b1;
        s_axis.i_s_axis_tdata  = d;
        for (int n = 0; n < 20 * FRAME; n++) begin
            rdy = s_axis.o_s_axis_tready;
            @(posedge clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1;
        acc = cyc;
        s_axis.i_s_axis_tvalid = 1'b0;
        if (ok) begin
            sb.push_back('{d, p});
        end else begin
            tests++;
            fails++;
            $display("FAIL push timeout: byte %02h not accepted, expected acceptance", d);
        end
    endtask

    task automatic wait_idle(input int bound);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0 && !rx_act) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL idle timeout: busy=%0d pending=%0d, expected idle", busy, sb.size());
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       p;
    } vec_t;

    initial begin
        vec_t vt[8];
        int   acc, s0, busy_cyc, done_cnt, gaps, lows, fr;
        bit   seen;

        vt = '{'{8'h55, 1'b0}, '{8'h01, 1'b1}, '{8'h80, 1'b1}, '{8'hFF, 1'b0},
               '{8'h07, 1'b1}, '{8'h03, 1'b0}, '{8'hA5, 1'b0}, '{8'h00, 1'b0}};

        s_axis.i_s_axis_tvalid = 1'b0;
        s_axis.i_s_axis_tdata  = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset txd", {31'd0, txd}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset tready", {31'd0, s_axis.o_s_axis_tready}, 32'd0);
        check("reset count", {29'd0, fcnt}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("tready before first edge", {31'd0, s_axis.o_s_axis_tready}, 32'd0);
        @(posedge clk);
        #1;
        check("tready after release", {31'd0, s_axis.o_s_axis_tready}, 32'd1);

        // Single frames from an idle block.
        for (int i = 0; i < 8; i++) begin
            s0 = starts.size();
            push(vt[i].d, vt[i].p, acc);
            busy_cyc = 0;
            done_cnt = 0;
            for (int n = 0; n < FRAME + 20; n++) begin
                @(negedge clk);
                if (busy) busy_cyc++;
                if (done) done_cnt++;
            end
            check("single frame start seen", starts.size(), s0 + 1);
            if (starts.size() > s0) check("start latency", starts[s0], acc + 2);
            check("frame busy cycles", busy_cyc, FRAME);
            check("done pulses per frame", done_cnt, 1);
            wait_idle(2 * FRAME);
        end

        // Burst: contiguous frames, busy never drops.
        s0 = starts.size();
        push(8'h01, 1'b1, acc);
        push(8'h80, 1'b1, acc);
        push(8'hFF, 1'b0, acc);
        push(8'h00, 1'b0, acc);
        gaps = 0;
        for (int n = 0; n < 6 * FRAME && sb.size() != 0; n++) begin
            @(negedge clk);
            if (!busy) gaps++;
        end
        check("burst busy gaps", gaps, 0);
        wait_idle(6 * FRAME);
        check("burst frame count", starts.size(), s0 + 4);
        for (int i = 0; i < 3; i++)
            if (starts.size() > s0 + i + 1)
                check("burst start spacing", starts[s0+i+1] - starts[s0+i], FRAME);

        // Full buffer: 8 bytes through a 4-deep buffer.
        fr = frames;
        max_cnt = 0;
        watch_full = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            b = 8'h10 + 8'(i * 17);
            push(b, ^b, acc);
        end
        wait_idle(12 * FRAME);
        watch_full = 1'b0;
        check("full max count", max_cnt, 4);
        check("full frames received", frames - fr, 8);

        // Simultaneous push and pop on the last stop cycle.
        s0 = starts.size();
        push(8'h3C, ^8'h3C, acc);
        push(8'hC3, ^8'hC3, acc);
        check("count before overlap", {29'd0, fcnt}, 32'd1);
        seen = 1'b0;
        for (int n = 0; n < 2 * FRAME; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done pulse seen", {31'd0, seen}, 32'd1);
        s_axis.i_s_axis_tvalid = 1'b1;
        s_axis.i_s_axis_tdata  = 8'h5A;
        sb.push_back('{8'h5A, ^8'h5A});
        @(posedge clk);
        #1;
        s_axis.i_s_axis_tvalid = 1'b0;
        check("count after push+pop", {29'd0, fcnt}, 32'd1);
        wait_idle(4 * FRAME);
        check("overlap frame count", starts.size(), s0 + 3);
        if (starts.size() > s0 + 2) begin
            check("overlap no gap", starts[s0+1] - starts[s0], FRAME);
            check("overlap next no gap", starts[s0+2] - starts[s0+1], FRAME);
        end

        // Reset during data bit 3 of 0xA5 with three bytes buffered.
        s0 = starts.size();
        push(8'hA5, 1'b0, acc);
        push(8'h11, ^8'h11, acc);
        push(8'h22, ^8'h22, acc);
        push(8'h33, ^8'h33, acc);
        check("count before reset", {29'd0, fcnt}, 32'd3);
        for (int n = 0; n < 2 * FRAME && starts.size() == s0; n++) @(negedge clk);
        check("reset frame started", starts.size(), s0 + 1);
        if (starts.size() > s0)
            for (int n = 0; n < 2 * FRAME && cyc < starts[s0] + 4 * CPB + 5; n++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort txd high", {31'd0, txd}, 32'd1);
        check("abort count", {29'd0, fcnt}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort tready", {31'd0, s_axis.o_s_axis_tready}, 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("tready after second release", {31'd0, s_axis.o_s_axis_tready}, 32'd1);
        fr = frames;
        s0 = starts.size();
        lows = 0;
        for (int n = 0; n < 3 * FRAME; n++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        check("line idle after reset", lows, 0);
        check("no frames after reset", starts.size(), s0);
        check("count stays zero", {29'd0, fcnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clock cycles per serial bit (legal range 4..65535).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, giving the byte buffer depth (power of two, 2..256).
REQ-003 The block SHALL have port i_clk  input  1  single clock; all logic is synchronous to its rising edge.
REQ-004 The block SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port i_s_axis_tvalid  input  1  AXIS slave byte valid.
REQ-006 The block SHALL have port o_s_axis_tready  output  1  AXIS slave ready; high when the buffer is not full.
REQ-007 The block SHALL have port i_s_axis_tdata  input  8  AXIS slave byte to transmit.
REQ-008 The block SHALL have port o_txd  output  1  serial TxD line; idle high.
REQ-009 The block SHALL have port o_txd_busy  output  1  high while a frame (start through last stop cycle) is on the line.
REQ-010 The block SHALL have port o_txd_done  output  1  one-cycle pulse on the final cycle of each stop bit.
REQ-011 The block SHALL have port o_fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered (not counting the byte being serialized).

Function
REQ-012 A byte SHALL be accepted on any rising edge where i_s_axis_tvalid and o_s_axis_tready are both high; o_fifo_count increments on that edge.
REQ-013 o_s_axis_tready SHALL be low when o_fifo_count equals FIFO_DEPTH and high otherwise.
REQ-014 The buffer SHALL be first-in first-out; pointers wrap modulo FIFO_DEPTH without loss or duplication.
REQ-015 The serializer FSM SHALL have states IDLE, START, DATA, PARITY (macro builds only), STOP.
REQ-016 In IDLE with o_fifo_count nonzero, the FSM SHALL pop one byte and enter START on the same edge; o_fifo_count decrements on that edge.
REQ-017 A push and pop on the same edge SHALL leave o_fifo_count unchanged and store the pushed byte.
REQ-018 A byte pushed into an empty idle block SHALL drive o_txd low starting exactly 2 rising edges after the accepting edge.
REQ-019 START SHALL drive o_txd low for exactly CLKS_PER_BIT cycles.
REQ-020 DATA SHALL drive the 8 bits LSB first, each for exactly CLKS_PER_BIT cycles, using a 3-bit index that ends at 7.
REQ-021 STOP SHALL drive o_txd high for exactly CLKS_PER_BIT cycles.
REQ-022 On the last STOP cycle o_txd_done SHALL be high for one cycle; on that edge the FSM SHALL pop and enter START if o_fifo_count is nonzero, otherwise enter IDLE.
REQ-023 Back-to-back frames SHALL therefore have no idle cycles between the stop bit and the next start bit.
REQ-024 o_txd_busy SHALL be high in every non-IDLE state and low in IDLE.
REQ-025 The bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and reset to zero on every state change.

Reset
REQ-026 While i_rst_n is low the block SHALL force o_txd=1, o_txd_busy=0, o_txd_done=0, o_s_axis_tready=0, o_fifo_count=0, FSM=IDLE.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately (o_txd high without waiting for a clock) and discard all buffered bytes.
REQ-028 o_s_axis_tready SHALL go high on the first rising edge after i_rst_n deasserts.

Configuration
REQ-029 With macro UART_TX_BUF_PARITY_EN defined, a PARITY state of CLKS_PER_BIT cycles SHALL follow DATA, driving the even-parity bit (XOR of the 8 data bits), giving an 11-bit frame.
REQ-030 Without UART_TX_BUF_PARITY_EN, DATA SHALL go directly to STOP, giving a 10-bit frame, and no parity logic SHALL be present.

Verification
REQ-031 Single byte: CLKS_PER_BIT=16, push 0x55 -> o_txd low 2 edges later, then 1,0,1,0,1,0,1,0 at 16 cycles per bit, stop high, one o_txd_done pulse, frame length 160 cycles.
REQ-032 Burst: push 0x01,0x80,0xFF,0x00 back-to-back -> four contiguous frames with no idle cycles, correct bytes decoded by a uart_rx checker, o_txd_busy continuously high.
REQ-033 Full: FIFO_DEPTH=4, hold tvalid high for 8 bytes while serializer busy -> tready low when count=4, no byte lost or duplicated, all 8 bytes received in order.
REQ-034 Simultaneous push/pop: push on the edge a frame ends with count=1 -> count stays 1, next frame starts with no gap.
REQ-035 Reset mid-DATA: assert i_rst_n low during bit 3 of 0xA5 with 3 bytes buffered -> o_txd high at once, count=0, after release line idle with no further frames.
REQ-036 Parity build: with UART_TX_BUF_PARITY_EN, push 0x07 -> parity bit 1 after data, 176-cycle frame; push 0x03 -> parity bit 0.
